// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared forwarding-select codes and hazard FSM states
package mips_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_sel_calc.sv
// rtl/fwd_sel_calc.sv - next EX operand-mux select for one source register
module fwd_sel_calc
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       sel
);

  // The younger producer (EX) wins; $0 is hardwired and never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (src_used && ex_regwrite && (ex_rd != '0) && (ex_rd == src)) begin
      sel = FWD_MEM;
    end else if (src_used && mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, stall/flush and mult/div start control
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_op,
  input  logic             id_hilo_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ex_branch_taken,
  input  logic             md_busy,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_start,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_e        state_q, state_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       next_a, next_b;
  logic             load_use, md_haz, stall, flush, advance;

  fwd_sel_calc #(.REG_W(REG_W)) u_fwd_a (
    .src(id_rs), .src_used(1'b1),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .sel(next_a)
  );

  fwd_sel_calc #(.REG_W(REG_W)) u_fwd_b (
    .src(id_rt), .src_used(id_uses_rt),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .sel(next_b)
  );

  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    md_haz   = (id_md_op || id_hilo_rd) && md_busy;
    flush    = ex_branch_taken;
    state_d  = state_q;
    stall    = 1'b0;
    // A taken branch kills the ID instruction, so no hazard on it matters.
    if (flush) begin
      state_d = HZ_RUN;
    end else if (state_q == HZ_RUN) begin
      stall = load_use || md_haz;
      if (md_haz) state_d = HZ_MD_WAIT;
    end else begin
      stall = md_busy || load_use;
      if (!md_busy) state_d = HZ_RUN;
    end

    pc_en      = !stall;
    ifid_en    = !stall;
    ifid_flush = flush;
    idex_flush = flush || stall;
    advance    = !stall && !flush;
    md_start   = id_md_op && advance;

    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (idex_flush) begin
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
    end else if (advance) begin
      fwd_a_d = next_a;
      fwd_b_d = next_b;
    end

    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rt, id_md_op, id_hilo_rd;
  logic       ex_regwrite, ex_memread, mem_regwrite, ex_branch_taken, md_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, md_start;
  logic [3:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_op(id_md_op), .id_hilo_rd(id_hilo_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .ex_branch_taken(ex_branch_taken), .md_busy(md_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .md_start(md_start), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_uses_rt = 0; id_md_op = 0; id_hilo_rd = 0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0;
    ex_branch_taken = 0; md_busy = 0;
  endtask

  // Moves to the next cycle's drive point; registered outputs have updated.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b_sel); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
    n_cmp++; if ({pc_en, ifid_en, ifid_flush, idex_flush, md_start} !== 5'b11000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 11000", {pc_en, ifid_en, ifid_flush, idex_flush, md_start}); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    idle();
    ex_regwrite = 1; ex_rd = 3; id_rs = 3;
    step();
    n_cmp++; if (fwd_a_sel !== 2'b10) begin n_err++; $display("FAIL fwd_ex_a: got %b want 10", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_ex_b: got %b want 00", fwd_b_sel); end
    idle();
    mem_regwrite = 1; mem_rd = 3; id_rs = 3; id_rt = 3; id_uses_rt = 1;
    step();
    n_cmp++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL fwd_mem_a: got %b want 01", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b01) begin n_err++; $display("FAIL fwd_mem_b: got %b want 01", fwd_b_sel); end
    ex_regwrite = 1; ex_rd = 3; id_uses_rt = 0;
    step();
    n_cmp++; if (fwd_a_sel !== 2'b10) begin n_err++; $display("FAIL fwd_both_a: got %b want 10", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_b_unused: got %b want 00", fwd_b_sel); end
  endtask

  task automatic test_zero_reg();
    idle();
    ex_regwrite = 1; ex_memread = 1; mem_regwrite = 1; id_uses_rt = 1;
    #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL zero_no_stall: got %b want 1", pc_en); end
    step();
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_err++; $display("FAIL zero_sel: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 1; id_rt = 5; id_uses_rt = 1;
    #1;
    n_cmp++; if ({pc_en, ifid_en, ifid_flush, idex_flush, md_start} !== 5'b00010) begin
      n_err++; $display("FAIL lu_ctrl: got %b want 00010", {pc_en, ifid_en, ifid_flush, idex_flush, md_start}); end
    step();
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", stall_cycles); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL lu_bubble_sel: got %b want 00", fwd_b_sel); end
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 5;
    #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL lu_one_cycle: got %b want 1", pc_en); end
    step();
    n_cmp++; if (fwd_b_sel !== 2'b01) begin n_err++; $display("FAIL lu_fwd_wb: got %b want 01", fwd_b_sel); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cycles); end
  endtask

  task automatic test_md();
    idle();
    id_md_op = 1;
    #1;
    n_cmp++; if ({pc_en, md_start} !== 2'b11) begin n_err++; $display("FAIL md_free_start: got %b want 11", {pc_en, md_start}); end
    md_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({pc_en, idex_flush, md_start} !== 3'b010) begin
        n_err++; $display("FAIL md_stall%0d: got %b want 010", i, {pc_en, idex_flush, md_start}); end
      step();
    end
    md_busy = 0;
    #1;
    n_cmp++; if ({pc_en, ifid_en, md_start} !== 3'b111) begin n_err++; $display("FAIL md_release: got %b want 111", {pc_en, ifid_en, md_start}); end
    step();
    id_md_op = 0;
    #1;
    n_cmp++; if (md_start !== 1'b0) begin n_err++; $display("FAIL md_single_pulse: got %b want 0", md_start); end
    n_cmp++; if (stall_cycles !== 4'd5) begin n_err++; $display("FAIL md_cnt: got %0d want 5", stall_cycles); end
  endtask

  task automatic test_flush_md();
    idle();
    id_hilo_rd = 1; md_busy = 1;
    step();
    ex_branch_taken = 1; ex_regwrite = 1; ex_rd = 7; id_rs = 7;
    #1;
    n_cmp++; if ({pc_en, ifid_en, ifid_flush, idex_flush, md_start} !== 5'b11110) begin
      n_err++; $display("FAIL flmd_ctrl: got %b want 11110", {pc_en, ifid_en, ifid_flush, idex_flush, md_start}); end
    step();
    ex_branch_taken = 0; id_hilo_rd = 0; ex_regwrite = 0;
    #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL flmd_state_run: got %b want 1", pc_en); end
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL flmd_sel: got %b want 00", fwd_a_sel); end
    n_cmp++; if (stall_cycles !== 4'd6) begin n_err++; $display("FAIL flmd_cnt: got %0d want 6", stall_cycles); end
  endtask

  task automatic test_flush_load_use();
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; ex_branch_taken = 1;
    #1;
    n_cmp++; if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1111) begin
      n_err++; $display("FAIL fllu_ctrl: got %b want 1111", {pc_en, ifid_en, ifid_flush, idex_flush}); end
    step();
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fllu_sel: got %b want 00", fwd_b_sel); end
    n_cmp++; if (stall_cycles !== 4'd6) begin n_err++; $display("FAIL fllu_cnt: got %0d want 6", stall_cycles); end
  endtask

  task automatic test_both_hazards();
    idle();
    ex_memread = 1; ex_rd = 4; id_rs = 4; id_md_op = 1; md_busy = 1;
    #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL both_stall: got %b want 0", pc_en); end
    step();
    ex_memread = 0; ex_rd = 0; id_md_op = 0;
    #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL both_md_wait: got %b want 0", pc_en); end
    step();
    md_busy = 0;
    #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL both_release: got %b want 1", pc_en); end
    step();
    n_cmp++; if (stall_cycles !== 4'd8) begin n_err++; $display("FAIL both_cnt: got %0d want 8", stall_cycles); end
  endtask

  task automatic test_reset_mid_md();
    idle();
    mem_regwrite = 1; mem_rd = 2; id_rs = 2;
    step();
    id_md_op = 1; md_busy = 1;
    step();
    n_cmp++; if (stall_cycles !== 4'd9) begin n_err++; $display("FAIL rmd_pre_cnt: got %0d want 9", stall_cycles); end
    #1;
    rst_n = 0;
    #1;
    id_md_op = 0;
    #1;
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL rmd_cnt: got %0d want 0", stall_cycles); end
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL rmd_sel: got %b want 00", fwd_a_sel); end
    n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL rmd_state_run: got %b want 1", pc_en); end
    step();
    rst_n = 1;
    md_busy = 0;
  endtask

  task automatic test_saturation();
    idle();
    id_md_op = 1; md_busy = 1;
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_cnt: got %0d want 15", stall_cycles); end
    md_busy = 0;
    step();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", stall_cycles); end
  endtask

  initial begin
    test_reset();
    step();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_md();
    test_flush_md();
    test_flush_load_use();
    test_both_hazards();
    test_reset_mid_md();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
